sipo_deserializer: RTL and testbench



---
 rtl/sipo_pkg.sv | 11 +
 rtl/sipo_out_reg.sv | 40 ++++
 rtl/sipo_deserializer.sv | 125 ++++++++++++
 tb/tb_sipo_deserializer.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared types for the serial receive path: deserializer FSM states and counter sizing.
package sipo_pkg;

  typedef enum logic [1:0] {IDLE, COLLECT, PARITY} state_t;

  // Bit counter must hold 0..width inclusive.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_out_reg.sv
// One-entry valid/ready holding register; word visible the cycle after load.
// A load while a word is held and not being consumed is dropped and sets sticky overrun.
module sipo_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             data_ready,
  input  logic             clear_overrun,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             overrun,
  output logic             load_acc
);

  // Consume and load on the same edge leaves the register full with no bubble.
  assign load_acc = load & (~data_valid | data_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (load_acc) begin
        data_out   <= word;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
      if (load && !load_acc)
        overrun <= 1'b1;
      else if (clear_overrun)
        overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// LSB-first serial-to-parallel receiver; word valid one cycle after its final bit, dropped with overrun if held word unconsumed.
// SIPO_PARITY_CHECK_EN adds a trailing even-parity bit per word and drives parity_err.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  serial_in,
  input  logic                  serial_valid,
  input  logic                  sync,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  overrun,
  input  logic                  clear_overrun,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic                  parity_err
);

  localparam int BW = cnt_width(DATA_WIDTH);
  localparam logic [BW-1:0] LAST = BW'(DATA_WIDTH - 1);
`ifdef SIPO_PARITY_CHECK_EN
  localparam int SW = DATA_WIDTH;      // full word kept while waiting for parity
  localparam int OW = DATA_WIDTH + 1;  // parity_err travels with the word
`else
  localparam int SW = DATA_WIDTH - 1;
  localparam int OW = DATA_WIDTH;
`endif

  state_t                state_q, state_d;
  logic [BW-1:0]         cnt_q, cnt_d;
  logic [SW-1:0]         shift_q, shift_d;
  logic [DATA_WIDTH-1:0] candidate;
  logic [OW-1:0]         word, out_word;
  logic                  load, load_acc;

  assign candidate = {serial_in, shift_q[SW-1 -: DATA_WIDTH-1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    load    = 1'b0;
`ifdef SIPO_PARITY_CHECK_EN
    word    = {^shift_q ^ serial_in, shift_q};
`else
    word    = candidate;
`endif
    if (sync) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (serial_valid) begin
      case (state_q)
        IDLE, COLLECT: begin
          shift_d = candidate[DATA_WIDTH-1 -: SW];
          if (cnt_q == LAST) begin
            cnt_d = '0;
`ifdef SIPO_PARITY_CHECK_EN
            state_d = PARITY;
`else
            state_d = IDLE;
            load    = 1'b1;
`endif
          end else begin
            cnt_d   = cnt_q + BW'(1);
            state_d = COLLECT;
          end
        end
`ifdef SIPO_PARITY_CHECK_EN
        PARITY: begin
          load    = 1'b1;
          state_d = IDLE;
        end
`endif
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  sipo_out_reg #(.WIDTH(OW)) u_out_reg (
    .clk           (clk),
    .reset         (reset),
    .load          (load),
    .word          (word),
    .data_ready    (data_ready),
    .clear_overrun (clear_overrun),
    .data_out      (out_word),
    .data_valid    (data_valid),
    .overrun       (overrun),
    .load_acc      (load_acc)
  );

  assign data_out = out_word[DATA_WIDTH-1:0];
`ifdef SIPO_PARITY_CHECK_EN
  assign parity_err = out_word[DATA_WIDTH];
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset)
      word_count <= '0;
    else if (load_acc)
      word_count <= word_count + CNT_WIDTH'(1);
  end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer (default build); inputs change and outputs are sampled on the falling edge.
module tb_sipo_deserializer;

  logic        clk = 1'b0;
  logic        reset;
  logic        serial_in, serial_valid, sync;
  logic [7:0]  data_out;
  logic        data_valid, data_ready;
  logic        overrun, clear_overrun;
  logic [15:0] word_count;
  logic        parity_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sipo_deserializer #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .serial_in     (serial_in),
    .serial_valid  (serial_valid),
    .sync          (sync),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .overrun       (overrun),
    .clear_overrun (clear_overrun),
    .word_count    (word_count),
    .parity_err    (parity_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    serial_in    = b;
    serial_valid = 1'b1;
    @(negedge clk);
    serial_valid = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit(w[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; serial_in = 1'b0; serial_valid = 1'b0; sync = 1'b0;
    data_ready = 1'b0; clear_overrun = 1'b0;
    idle(2);
    check("rst_data",   data_out,   8'h00);
    check("rst_valid",  data_valid, 1'b0);
    check("rst_ovr",    overrun,    1'b0);
    check("rst_cnt",    word_count, 16'd0);
    check("rst_parity", parity_err, 1'b0);
    reset = 1'b0;
    idle(1);

    // Single word, consumer ready: valid exactly after the 8th bit.
    data_ready = 1'b1;
    send_bits(8'hA5, 7);
    check("a5_valid_early", data_valid, 1'b0);
    send_bit(1'b1);
    check("a5_data",  data_out,   8'hA5);
    check("a5_valid", data_valid, 1'b1);
    check("a5_cnt",   word_count, 16'd1);
    idle(1);
    check("a5_consumed", data_valid, 1'b0);
    check("a5_hold",     data_out,   8'hA5);

    // Stalled consumer: second word dropped, overrun set wins over clear.
    data_ready = 1'b0;
    send_bits(8'h3C, 8);
    check("3c_data", data_out,   8'h3C);
    check("3c_cnt",  word_count, 16'd2);
    send_bits(8'hC3, 7);
    clear_overrun = 1'b1;
    send_bit(1'b1);
    check("c3_data_kept", data_out,   8'h3C);
    check("c3_ovr",       overrun,    1'b1);
    check("c3_cnt",       word_count, 16'd2);
    check("c3_valid",     data_valid, 1'b1);
    idle(1);
    clear_overrun = 1'b0;
    check("ovr_cleared", overrun, 1'b0);
    data_ready = 1'b1;
    idle(1);
    check("3c_consumed", data_valid, 1'b0);

    // Consume and load on the same edge.
    data_ready = 1'b0;
    send_bits(8'h11, 8);
    check("11_data", data_out, 8'h11);
    send_bits(8'h22, 7);
    check("22_pre_valid", data_valid, 1'b1);
    data_ready = 1'b1;
    send_bit(1'b0);
    check("22_data",  data_out,   8'h22);
    check("22_valid", data_valid, 1'b1);
    check("22_ovr",   overrun,    1'b0);
    check("22_cnt",   word_count, 16'd4);
    idle(1);
    check("22_consumed", data_valid, 1'b0);

    // Partial word discarded by sync; bit presented with sync is ignored.
    send_bits(8'hFF, 5);
    sync = 1'b1; serial_in = 1'b1; serial_valid = 1'b1;
    @(negedge clk);
    sync = 1'b0; serial_valid = 1'b0;
    check("sync_valid", data_valid, 1'b0);
    send_bits(8'h5A, 8);
    check("5a_data",  data_out,   8'h5A);
    check("5a_valid", data_valid, 1'b1);
    check("5a_cnt",   word_count, 16'd5);
    idle(1);

    // Reset mid-word.
    send_bits(8'h0F, 4);
    reset = 1'b1;
    idle(1);
    check("mrst_data",  data_out,   8'h00);
    check("mrst_valid", data_valid, 1'b0);
    check("mrst_cnt",   word_count, 16'd0);
    check("mrst_ovr",   overrun,    1'b0);
    reset = 1'b0;
    send_bits(8'hFF, 7);
    check("ff_valid_early", data_valid, 1'b0);
    send_bit(1'b1);
    check("ff_data",   data_out,   8'hFF);
    check("ff_cnt",    word_count, 16'd1);
    check("ff_parity", parity_err, 1'b0);

    // Gaps between bits are legal.
    idle(1);
    for (int i = 0; i < 8; i++) begin
      send_bit(i[0] ? 1'b0 : 1'b1);  // 0x55 LSB first
      idle(2);
    end
    check("gap_data", data_out,   8'h55);
    check("gap_cnt",  word_count, 16'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
